imm_gen_pipe: RTL

//  Pipelined, parametrised immediate generator for the RV32I/RV64I core.

---
 rtl/imm_gen_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with valid/ready handshakes on
// both sides, a synchronous flush and a saturating illegal-opcode counter.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_CSRZ  = 3'd7;
  localparam int         LAST      = STAGES - 1;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [31:0]     ext32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];

  // Every format is first built as a 32-bit sign/zero-extended value, then
  // widened to XLEN by sign extension (zero-extended fields have bit 31 clear).
  always_comb begin
    ext32   = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (op)
      7'b0000011, 7'b1100111: begin
        ext32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0010011: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          ext32   = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};
          dec_fmt = FMT_SHAMT;
        end else begin
          ext32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt = FMT_I;
        end
      end
      7'b0011011: begin
        if (XLEN != 64) begin
          dec_ill = 1'b1;
        end else if (f3 == 3'b001 || f3 == 3'b101) begin
          ext32   = {27'b0, in_instr[24:20]};
          dec_fmt = FMT_SHAMT;
        end else begin
          ext32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt = FMT_I;
        end
      end
      7'b0100011: begin
        ext32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        ext32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        ext32   = {in_instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        ext32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      7'b1110011: begin
        if (f3[2]) begin
          ext32   = {27'b0, in_instr[19:15]};
          dec_fmt = FMT_CSRZ;
        end else begin
          ext32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec_fmt = FMT_I;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_imm = XLEN'($signed(ext32));

  logic [STAGES-1:0] vld_reg;
  logic [XLEN-1:0]   imm_reg [STAGES];
  logic [2:0]        fmt_reg [STAGES];
  logic [STAGES-1:0] ill_reg;
  logic [STAGES-1:0] rdy;
  logic              take_out;

  // A stage can load when it is empty or its content moves on this cycle.
  always_comb begin
    rdy       = '0;
    rdy[LAST] = !vld_reg[LAST] || out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      rdy[k] = !vld_reg[k] || rdy[k+1];
    end
  end

  assign in_ready    = !flush && rdy[0];
  assign out_valid   = vld_reg[LAST];
  assign out_imm     = imm_reg[LAST];
  assign out_fmt     = fmt_reg[LAST];
  assign out_illegal = ill_reg[LAST];
  assign take_out    = out_valid && out_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg     <= '0;
      ill_reg     <= '0;
      illegal_cnt <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_reg[k] <= '0;
        fmt_reg[k] <= '0;
      end
    end else begin
      if (flush) begin
        vld_reg <= '0;
      end else begin
        if (rdy[0]) begin
          vld_reg[0] <= in_valid;
          if (in_valid) begin
            imm_reg[0] <= dec_imm;
            fmt_reg[0] <= dec_fmt;
            ill_reg[0] <= dec_ill;
          end
        end
        for (int k = 1; k < STAGES; k++) begin
          if (rdy[k]) begin
            vld_reg[k] <= vld_reg[k-1];
            if (vld_reg[k-1]) begin
              imm_reg[k] <= imm_reg[k-1];
              fmt_reg[k] <= fmt_reg[k-1];
              ill_reg[k] <= ill_reg[k-1];
            end
          end
        end
      end
      if (take_out && out_illegal && (illegal_cnt != '1)) begin
        illegal_cnt <= illegal_cnt + 1'b1;
      end
    end
  end

endmodule
